vram_arbiter: RTL and testbench

- Shares the single-port 2Kx8 video/work RAM between the 6502 CPU port and the video tile-fetch path, which feeds the shift-register/colour-PROM pipeline.
- Video fetch slots come from the horizontal timer and always win.
- CPU writes are posted into a one-entry buffer. CPU reads stall the core through `cpu_ready` until a free RAM cycle returns the data.
- Sits between the CPU address decode (RAM chip-select) and the RAM macro. It replaces a true dual-port RAM.

---
 rtl/tankb_pkg.sv | 31 +++
 rtl/vram_wbuf.sv | 62 ++++++
 rtl/vram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tankb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tankb_pkg
// Description : Shared types and default widths for the video-RAM arbiter.
//               Default address/data/counter widths, the CPU read-FSM state
//               encoding and the RAM-cycle owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tankb_pkg;

  localparam int C_ADDR_W = 11;  // 2K bytes of video/work RAM
  localparam int C_DATA_W = 8;
  localparam int C_CNT_W  = 16;

  // CPU read sequencer
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

  // Who drives the RAM this cycle, listed highest priority first
  typedef enum logic [1:0] {
    OWN_VID    = 2'd0,
    OWN_WDRAIN = 2'd1,
    OWN_CPURD  = 2'd2,
    OWN_IDLE   = 2'd3
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/vram_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : vram_wbuf
// Description : One-entry posted-write buffer for CPU writes into the shared
//               RAM, with address compare so a read of the buffered address
//               can be served from the buffer.
// Ports       : clk, rst        - clock, async active-high reset
//               wr_req/addr/data - CPU write offered this cycle
//               wr_accept        - write accepted (buffer was empty)
//               drain            - buffer contents go to RAM this cycle
//               rd_addr, rd_hit  - forwarding lookup
//               valid/addr/data  - current buffer contents
// Revision    : 1.0 - initial release
// ============================================================================
module vram_wbuf
  import tankb_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_accept,
  input  logic              drain,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Acceptance looks at the registered valid flag, so a write offered in the
  // drain cycle waits one more cycle.
  assign wr_accept = wr_req && !r_valid;
  assign rd_hit    = r_valid && (rd_addr == r_addr);
  assign valid     = r_valid;
  assign addr      = r_addr;
  assign data      = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (wr_accept) begin
      r_valid <= 1'b1;
      r_addr  <= wr_addr;
      r_data  <= wr_data;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares a single-port synchronous-read RAM between the video
//               tile-fetch path and the CPU. Video slots always win; CPU
//               writes are posted into a one-entry buffer; CPU reads stall
//               through cpu_ready until a free RAM cycle returns the data.
// Ports       : clk, rst                 - clock, async active-high reset
//               vid_slot/vid_addr        - video fetch request
//               vid_data/vid_valid       - fetched byte, two cycles later
//               cpu_req/we/addr/wdata    - CPU access, held until cpu_ready
//               cpu_rdata/cpu_ready      - CPU completion (combinational)
//               ram_addr/we/wdata/rdata  - RAM macro interface
//               stall_cnt                - saturating CPU stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
  import tankb_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_slot,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  owner_t            w_owner;

  logic              r_vid_p1;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_wr_req;
  logic              w_wr_accept;
  logic              w_drain;
  logic              w_rd_hit;
  logic              w_buf_valid;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_data;

  // --------------------------------------------------------------------------
  // Posted-write buffer. Writes are only taken while no read is in flight;
  // the CPU holds its request, so this never drops a write.
  // --------------------------------------------------------------------------
  assign w_wr_req = cpu_req && cpu_we && !rst && (r_state == IDLE);
  assign w_drain  = (w_owner == OWN_WDRAIN);

  vram_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (w_wr_req),
    .wr_addr   (cpu_addr),
    .wr_data   (cpu_wdata),
    .wr_accept (w_wr_accept),
    .drain     (w_drain),
    .rd_addr   (cpu_addr),
    .rd_hit    (w_rd_hit),
    .valid     (w_buf_valid),
    .addr      (w_buf_addr),
    .data      (w_buf_data)
  );

  // --------------------------------------------------------------------------
  // RAM-cycle owner. A read is issued only from RD_ISSUE once both video and
  // the write buffer leave the cycle free.
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner = OWN_IDLE;
    if (!rst) begin
      if (vid_slot)                w_owner = OWN_VID;
      else if (w_buf_valid)        w_owner = OWN_WDRAIN;
      else if (r_state == RD_ISSUE) w_owner = OWN_CPURD;
    end
  end

  // The address is combinational so a synchronous-read RAM returns data one
  // cycle after the owner cycle; idle cycles replay the last address.
  always_comb begin
    ram_addr = r_addr_hold;
    case (w_owner)
      OWN_VID:    ram_addr = vid_addr;
      OWN_WDRAIN: ram_addr = w_buf_addr;
      OWN_CPURD:  ram_addr = cpu_addr;
      default:    ram_addr = r_addr_hold;
    endcase
  end

  assign ram_we    = w_drain;
  assign ram_wdata = w_buf_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold <= '0;
    end else if (w_owner != OWN_IDLE) begin
      r_addr_hold <= ram_addr;
    end
  end

  // --------------------------------------------------------------------------
  // CPU read FSM and handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (!cpu_req) begin
            cpu_ready = 1'b1;
          end else if (cpu_we) begin
            cpu_ready = w_wr_accept;
          end else if (w_rd_hit) begin
            // Newest data still sits in the buffer: answer with zero wait
            cpu_ready = 1'b1;
            cpu_rdata = w_buf_data;
          end else begin
            w_state_nxt = RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (w_owner == OWN_CPURD) w_state_nxt = RD_DATA;
        end
        RD_DATA: begin
          cpu_ready   = 1'b1;
          cpu_rdata   = ram_rdata;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Video return pipeline: slot at T, RAM data during T+1, registered so it
  // is presented during T+2.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vid_p1    <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_vid_p1    <= vid_slot;
      r_vid_valid <= r_vid_p1;
      if (r_vid_p1) r_vid_data <= ram_rdata;
    end
  end

  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;

  // --------------------------------------------------------------------------
  // Saturating stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (cpu_req && !cpu_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Self-checking bench for vram_arbiter. Directed scenarios
//               followed by a randomized run checked against a memory-level
//               reference (latest-written value per address, fixed video
//               latency). The RAM macro is modelled here with a backdoor
//               write port used for preloading.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_slot;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [CW-1:0] stall_cnt;

  // RAM model with backdoor preload
  logic [DW-1:0] mem [0:2047];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  // reference memory contents as seen by the CPU
  logic [DW-1:0] ref_mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .vid_slot  (vid_slot),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .stall_cnt (stall_cnt)
  );

  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'b10101};
  endfunction

  // one cycle: resume 1 ns after the rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle before sampling
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    vid_slot  = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    #1;
    for (int i = 0; i < 2048; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      bd_we = 1'b1; bd_addr = a;
      bd_data = (a == 11'h123) ? 8'hA5 : (a == 11'h200) ? 8'h77 : pat(a);
      ref_mem[i] = bd_data;
      tick();
    end
    bd_we = 1'b0;
    settle();
    n_cmp++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL rst_vid_valid: got %b want 0", vid_valid); end
    n_cmp++; if (vid_data !== 8'h00) begin n_err++; $display("FAIL rst_vid_data: got %h want 00", vid_data); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 11'h000) begin n_err++; $display("FAIL rst_ram_addr: got %h want 000", ram_addr); end
    n_cmp++; if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL rst_ram_wdata: got %h want 00", ram_wdata); end
    n_cmp++; if (stall_cnt !== 4'h0) begin n_err++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    tick();
    rst = 1'b0;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", cpu_ready); end
    tick(); tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_video_fetch();
    vid_slot = 1'b1; vid_addr = 11'h123;
    settle();
    n_cmp++; if (ram_addr !== 11'h123 || ram_we !== 1'b0) begin n_err++; $display("FAIL vid_addr_T: got addr %h we %b want 123 0", ram_addr, ram_we); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL vid_cpu_ready: got %b want 1", cpu_ready); end
    tick();
    vid_slot = 1'b0;
    settle();
    n_cmp++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL vid_valid_T1: got %b want 0", vid_valid); end
    tick();
    settle();
    n_cmp++; if (vid_valid !== 1'b1 || vid_data !== 8'hA5) begin n_err++; $display("FAIL vid_data_T2: got v%b %h want v1 a5", vid_valid, vid_data); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL vid_cpu_ready_T2: got %b want 1", cpu_ready); end
    tick();
    settle();
    n_cmp++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL vid_valid_T3: got %b want 0", vid_valid); end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_posted_write_hit();
    vid_slot = 1'b1; vid_addr = 11'h400;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040; cpu_wdata = 8'h5A;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL post_wr_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL post_wr_no_we: got %b want 0", ram_we); end
    tick();
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL fwd_read: got rdy %b %h want 1 5a", cpu_ready, cpu_rdata); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL fwd_no_drain_under_vid: got %b want 0", ram_we); end
    tick();
    idle_inputs();
    settle();
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'h040 || ram_wdata !== 8'h5A) begin
      n_err++; $display("FAIL drain: got we %b %h<-%h want 1 040<-5a", ram_we, ram_addr, ram_wdata); end
    tick();
    settle();
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL drain_once: got %b want 0", ram_we); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL post_no_stall: got %0d want 0", stall_cnt); end
    n_cmp++; if (mem[11'h040] !== 8'h5A) begin n_err++; $display("FAIL post_mem: got %h want 5a", mem[11'h040]); end
    ref_mem[11'h040] = 8'h5A;
    tick(); tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_read_miss_contention();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
    for (int c = 0; c < 4; c++) begin
      vid_slot = (c < 3); vid_addr = 11'h401;
      settle();
      n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL miss_stall_c%0d: got %b want 0", c, cpu_ready); end
      if (c == 3) begin
        n_cmp++; if (ram_addr !== 11'h200 || ram_we !== 1'b0) begin n_err++; $display("FAIL miss_issue: got %h we %b want 200 0", ram_addr, ram_we); end
      end
      tick();
    end
    settle();
    n_cmp++; if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h77) begin n_err++; $display("FAIL miss_data: got rdy %b %h want 1 77", cpu_ready, cpu_rdata); end
    n_cmp++; if (stall_cnt !== 4'd4) begin n_err++; $display("FAIL miss_stall_cnt: got %0d want 4", stall_cnt); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_write_full();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h11;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL wf_first: got %b want 1", cpu_ready); end
    tick();
    cpu_addr = 11'h011; cpu_wdata = 8'h22;
    settle();
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL wf_second_wait: got %b want 0", cpu_ready); end
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'h010) begin n_err++; $display("FAIL wf_drain1: got we %b %h want 1 010", ram_we, ram_addr); end
    tick();
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL wf_second_accept: got %b want 1", cpu_ready); end
    tick();
    idle_inputs();
    settle();
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'h011 || ram_wdata !== 8'h22) begin
      n_err++; $display("FAIL wf_drain2: got we %b %h<-%h want 1 011<-22", ram_we, ram_addr, ram_wdata); end
    n_cmp++; if (stall_cnt !== 4'd5) begin n_err++; $display("FAIL wf_stall_cnt: got %0d want 5", stall_cnt); end
    tick(); tick();
    n_cmp++; if (mem[11'h010] !== 8'h11 || mem[11'h011] !== 8'h22) begin
      n_err++; $display("FAIL wf_mem: got %h %h want 11 22", mem[11'h010], mem[11'h011]); end
    ref_mem[11'h010] = 8'h11;
    ref_mem[11'h011] = 8'h22;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_saturation_and_reset();
    vid_slot = 1'b1; vid_addr = 11'h402;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h050; cpu_wdata = 8'hEE;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL sat_post: got %b want 1", cpu_ready); end
    tick();
    cpu_we = 1'b0; cpu_addr = 11'h200;
    for (int c = 0; c < 20; c++) tick();
    settle();
    n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_cnt: got %h want f", stall_cnt); end
    n_cmp++; if (cpu_ready !== 1'b0 || vid_valid !== 1'b1) begin n_err++; $display("FAIL sat_state: got rdy %b vv %b want 0 1", cpu_ready, vid_valid); end
    tick();
    rst = 1'b1;
    settle();
    n_cmp++; if ({vid_valid, vid_data, ram_we, ram_addr, ram_wdata, stall_cnt, cpu_rdata, cpu_ready} !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got vv%b vd%h we%b a%h wd%h sc%h rd%h rdy%b want all 0",
                        vid_valid, vid_data, ram_we, ram_addr, ram_wdata, stall_cnt, cpu_rdata, cpu_ready); end
    tick();
    idle_inputs();
    tick();
    rst = 1'b0;
    settle();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", cpu_ready); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (ram_we !== 1'b0 || vid_valid !== 1'b0) begin n_err++; $display("FAIL midrst_quiet_c%0d: got we %b vv %b want 0 0", c, ram_we, vid_valid); end
      tick();
      settle();
    end
    n_cmp++; if (mem[11'h050] !== ref_mem[11'h050]) begin n_err++; $display("FAIL midrst_write_lost: got %h want %h", mem[11'h050], ref_mem[11'h050]); end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic          busy;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    int            waited;
    int            done;
    logic          hist_v [2];
    logic [AW-1:0] hist_a [2];
    busy = 1'b0; done = 0; waited = 0;
    t_we = 1'b0; t_addr = '0; t_data = '0;
    hist_v[0] = 1'b0; hist_v[1] = 1'b0; hist_a[0] = '0; hist_a[1] = '0;
    idle_inputs();
    for (int cyc = 0; cyc < 3000 && done < 300; cyc++) begin
      vid_slot = ($urandom_range(0, 9) < 3);
      vid_addr = 11'h400 + AW'($urandom_range(0, 1023));
      if (!busy && $urandom_range(0, 1) == 1) begin
        busy   = 1'b1;
        waited = 0;
        t_we   = $urandom_range(0, 1) == 1;
        t_addr = 11'h080 + AW'($urandom_range(0, 7));
        t_data = DW'($urandom);
      end
      cpu_req = busy; cpu_we = t_we; cpu_addr = t_addr; cpu_wdata = t_data;
      settle();
      if (vid_slot) begin
        n_cmp++; if (ram_addr !== vid_addr || ram_we !== 1'b0) begin n_err++; $display("FAIL rnd_vid_own: got %h we %b want %h 0", ram_addr, ram_we, vid_addr); end
      end
      n_cmp++; if (vid_valid !== hist_v[1]) begin n_err++; $display("FAIL rnd_vid_valid: got %b want %b", vid_valid, hist_v[1]); end
      else if (hist_v[1]) begin
        n_cmp++; if (vid_data !== pat(hist_a[1])) begin n_err++; $display("FAIL rnd_vid_data: addr %h got %h want %h", hist_a[1], vid_data, pat(hist_a[1])); end
      end
      if (busy) begin
        if (cpu_ready) begin
          if (!t_we) begin
            n_cmp++; if (cpu_rdata !== ref_mem[t_addr]) begin n_err++; $display("FAIL rnd_read: addr %h got %h want %h", t_addr, cpu_rdata, ref_mem[t_addr]); end
          end else begin
            ref_mem[t_addr] = t_data;
          end
          busy = 1'b0;
          done++;
        end else begin
          waited++;
          if (waited > 60) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_timeout: addr %h we %b waited %0d cycles want <= 60", t_addr, t_we, waited);
            busy = 1'b0;
            done++;
          end
        end
      end else begin
        n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rnd_idle_ready: got %b want 1", cpu_ready); end
      end
      hist_v[1] = hist_v[0]; hist_a[1] = hist_a[0];
      hist_v[0] = vid_slot;  hist_a[0] = vid_addr;
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    for (int a = 11'h080; a < 11'h088; a++) begin
      n_cmp++; if (mem[a] !== ref_mem[a]) begin n_err++; $display("FAIL rnd_mem: addr %h got %h want %h", a, mem[a], ref_mem[a]); end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_video_fetch();
    test_posted_write_hit();
    test_read_miss_contention();
    test_write_full();
    test_saturation_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
